// File: rtl/pc_fetch_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_pkg
// Shared types and constants for the program-counter / instruction-fetch
// stage: the fetch FSM state encoding, the canonical RISC-V NOP encoding and
// the default reset PC and sequential increment.
// ---------------------------------------------------------------------------
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_INC   = 4;

endpackage

// File: rtl/pc_fetch_unit_fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// One-entry valid/ready holding register for {instr, instr_pc} toward decode.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           drop the held entry (redirect); wins over load and pop
//   load            capture load_instr/load_pc (only asserted when empty)
//   load_instr/pc   word and its PC coming back from instruction memory
//   out_valid       entry held
//   out_ready       consumer accepts the entry this cycle
//   out_instr/pc    held word and PC; stable while out_valid & !out_ready
// ---------------------------------------------------------------------------
module fetch_buffer
    import pc_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_instr,
    input  logic [DATA_WIDTH-1:0] load_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0] out_pc
);

    // Data registers are reset as well so decode sees zeros, not X, after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_instr <= load_instr;
            out_pc    <= load_pc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program counter and instruction fetch. Keeps at most one imem request in
// flight, buffers the returned word for decode, and on a taken jump/branch
// reloads the PC, squashes any wrong-path word and pulses flush.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   branchN, isBranch, isJump redirect qualifiers from EX / comparator
//   branchTarget              redirect target (low two bits ignored)
//   imem_req_valid/ready      fetch request handshake, imem_addr = pc
//   imem_rsp_valid/data       returned instruction word (no backpressure)
//   instr_valid/ready         decode handshake for instr / instr_pc
//   flush                     kill younger stages (same cycle as redirect)
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    PC_INC     = DEFAULT_PC_INC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branchN,
    input  logic                  isBranch,
    input  logic                  isJump,
    input  logic [DATA_WIDTH-1:0] branchTarget,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  flush
);

    fetch_state_t          state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] req_pc;
    logic                  squash;

    logic take;
    logic req_fire;
    logic rsp_fire;
    logic buf_load;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
        return a & ~DATA_WIDTH'(3);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] next_seq_pc(input logic [DATA_WIDTH-1:0] a);
        return a + DATA_WIDTH'(PC_INC);
    endfunction

    assign take  = isJump | (isBranch & branchN);
    assign flush = take;

    // A new request is only issued when the buffer will have room for its
    // response; together with the single outstanding request this guarantees
    // the buffer is empty whenever a response lands.
    assign imem_req_valid = (state == REQ) && (!instr_valid || instr_ready);
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses outside WAIT_RSP (e.g. a stale one just after rst) are ignored.
    assign rsp_fire = (state == WAIT_RSP) && imem_rsp_valid;
    assign buf_load = rsp_fire && !squash && !take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
            squash <= 1'b0;
        end else if (take) begin
            pc <= word_align(branchTarget);
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    // The request leaving now is wrong-path; kill its response.
                    if (req_fire) begin
                        req_pc <= pc;
                        state  <= WAIT_RSP;
                        squash <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_fire) begin
                        state  <= REQ;
                        squash <= 1'b0;
                    end else begin
                        squash <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        pc     <= next_seq_pc(pc);
                        state  <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_fire) begin
                        state  <= REQ;
                        squash <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (take),
        .load      (buf_load),
        .load_instr(imem_rsp_data),
        .load_pc   (req_pc),
        .out_valid (instr_valid),
        .out_ready (instr_ready),
        .out_instr (instr),
        .out_pc    (instr_pc)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        branchN, isBranch, isJump;
    logic [31:0] branchTarget;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        flush;

    always #5 clk = ~clk;

    pc_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0), .PC_INC(4)) dut (
        .clk(clk), .rst(rst), .branchN(branchN), .isBranch(isBranch), .isJump(isJump),
        .branchTarget(branchTarget), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .flush(flush)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: in-flight fetches as a queue of {pc, killed}, decode buffer as a queue.
    typedef struct { logic [31:0] pc; bit dead; } fl_t;
    typedef struct { logic [31:0] ins; logic [31:0] pc; } bf_t;
    fl_t         inf[$];
    bf_t         bq[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_run = 0, m_zero = 1, m_known = 0;

    // Instruction memory stand-in.
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          lat_lo = 0, lat_hi = 0;
    bit          rdy_rand = 0;
    int          acc_cnt = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit bn, input bit ib, input bit ij,
                        input logic [31:0] tg, input bit ir);
        bit  take, erv, fire, rsp, acc;
        fl_t e;
        rst = r; branchN = bn; isBranch = ib; isJump = ij; branchTarget = tg; instr_ready = ir;
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend && cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(pend_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (pend) cnt--;
        end
        #2;
        take = ij | (ib & bn);
        erv  = m_run && inf.size() == 0 && (bq.size() == 0 || ir);
        if (m_known) begin
            chk("flush", flush, take);
            chk("imem_req_valid", imem_req_valid, erv);
            chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", instr_valid, bq.size() != 0);
            if (bq.size() != 0) begin
                chk("instr", instr, bq[0].ins);
                chk("instr_pc", instr_pc, bq[0].pc);
            end else if (m_zero) begin
                chk("instr_rst", instr, 32'h0);
                chk("instr_pc_rst", instr_pc, 32'h0);
            end
        end
        acc = imem_req_valid & imem_req_ready;
        if (acc) acc_cnt++;
        if (imem_rsp_valid) pend = 0;
        if (acc) begin
            pend = 1;
            cnt = $urandom_range(lat_lo, lat_hi);
            pend_addr = imem_addr;
        end
        if (r) begin
            m_known = 1; m_run = 0; m_zero = 1; m_pc = 32'h0;
            inf.delete(); bq.delete();
        end else begin
            fire = erv & imem_req_ready;
            rsp  = imem_rsp_valid && inf.size() != 0;
            if (take) begin
                foreach (inf[i]) inf[i].dead = 1;
                bq.delete();
                if (rsp) void'(inf.pop_front());
                if (fire) inf.push_back(fl_t'{pc: m_pc, dead: 1'b1});
                m_pc = tg & ~32'h3;
            end else begin
                if (bq.size() != 0 && ir) void'(bq.pop_front());
                if (rsp) begin
                    e = inf.pop_front();
                    if (!e.dead) begin
                        bq.push_back(bf_t'{ins: word_of(e.pc), pc: e.pc});
                        m_zero = 0;
                    end
                end
                if (fire) begin
                    inf.push_back(fl_t'{pc: m_pc, dead: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_run = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop_step();
        step(0, 0, 0, 0, 32'h0, 1);
    endtask

    // Advance until the model says a request may be issued, bounded.
    task automatic goto_req(input string tag);
        int k = 0;
        while (!(m_run && inf.size() == 0) && k < 40) begin
            nop_step();
            k++;
        end
        n_chk++;
        assert (k < 40) else begin
            n_fail++;
            $error("FAIL %s_timeout: observed %0d cycles expected <40", tag, k);
        end
    endtask

    initial begin
        int a0;
        rst = 1'b1; branchN = 0; isBranch = 0; isJump = 0; branchTarget = 32'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; instr_ready = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset, then sequential fetch with 1-cycle imem
        repeat (3) step(1, 0, 0, 0, 32'h0, 1);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        goto_req("t1a"); chk("t1_addr0", imem_addr, 32'h0);
        nop_step();
        goto_req("t1b"); chk("t1_addr4", imem_addr, 32'h4);
        nop_step();
        goto_req("t1c"); chk("t1_addr8", imem_addr, 32'h8);

        // 2: decode stalls for 5 cycles
        a0 = acc_cnt;
        nop_step();
        repeat (5) step(0, 0, 0, 0, 32'h0, 0);
        chk("t2_one_req", acc_cnt - a0, 1);
        chk("t2_held_pc", instr_pc, 32'h8);
        chk("t2_held_instr", instr, word_of(32'h8));

        // 3: taken branch while waiting on a 2-cycle response
        lat_lo = 1; lat_hi = 1;
        goto_req("t3a");
        nop_step();
        step(0, 1, 1, 0, 32'h100, 1);
        goto_req("t3b");
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_dropped", instr_valid, 1'b0);

        // 4: not-taken branch, then jump to unaligned target
        lat_lo = 0; lat_hi = 0;
        nop_step();
        step(0, 0, 1, 0, 32'h999, 1);
        goto_req("t4a"); chk("t4_seq", imem_addr, 32'h104);
        nop_step();
        step(0, 0, 0, 1, 32'h203, 1);
        goto_req("t4b"); chk("t4_jump", imem_addr, 32'h200);

        // 5: redirect in the same cycle as the request at 0x40
        nop_step();
        step(0, 0, 0, 1, 32'h40, 1);
        goto_req("t5a"); chk("t5_at40", imem_addr, 32'h40);
        step(0, 0, 0, 1, 32'h80, 1);
        goto_req("t5b"); chk("t5_addr", imem_addr, 32'h80);
        chk("t5_dropped", instr_valid, 1'b0);

        // 6: PC wrap, then reset while a response is outstanding
        nop_step();
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        goto_req("t6a"); chk("t6_top", imem_addr, 32'hFFFF_FFFC);
        nop_step();
        goto_req("t6b"); chk("t6_wrap", imem_addr, 32'h0);
        chk("t6_wrap_pc", instr_pc, 32'hFFFF_FFFC);
        lat_lo = 1; lat_hi = 1;
        nop_step();
        step(1, 0, 0, 0, 32'h0, 1);
        chk("t6_rst_req", imem_req_valid, 1'b0);
        chk("t6_rst_iv", instr_valid, 1'b0);
        chk("t6_rst_instr", instr, 32'h0);
        chk("t6_rst_ipc", instr_pc, 32'h0);
        nop_step();
        goto_req("t6c"); chk("t6_refetch", imem_addr, 32'h0);
        chk("t6_stale_ignored", instr_valid, 1'b0);

        // Randomized traffic against the model
        lat_lo = 0; lat_hi = 3; rdy_rand = 1;
        repeat (2000) begin
            step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                 $urandom, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
